// File: rtl/bram_sp_reader_if.sv
// Handshake bundle between bram_sp_reader, its BRAM port and the stream sink.
// master = the reader, slave = the environment (BRAM plus sink plus requester).
interface bram_sp_reader_if #(
   parameter int DW = 8,
   parameter int AW = 4
);
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   len;
   logic          bram_wr;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_data_out;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;

   modport master (
      input  start, start_addr, len, bram_data_out, out_ready,
      output bram_wr, bram_addr, out_data, out_valid, out_last, busy, done
   );

   modport slave (
      output start, start_addr, len, bram_data_out, out_ready,
      input  bram_wr, bram_addr, out_data, out_valid, out_last, busy, done
   );
endinterface

// File: rtl/bram_sp_reader.sv
// Burst reader: streams len consecutive words (wrapping) out of a 1-cycle-latency
// single-port BRAM through a 4-entry credit-controlled FIFO with valid/ready output.
module bram_sp_reader #(
   parameter int RAM_DATA_WIDTH = 8,
   parameter int RAM_ADDR_WIDTH = 4
) (
   input logic              clk,
   input logic              rst,
   bram_sp_reader_if.master bus
);
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                    state_reg;
   logic [RAM_ADDR_WIDTH-1:0] addr_reg;
   logic [RAM_ADDR_WIDTH:0]   rd_left_reg;
   logic                      pend_reg;
   logic                      pend_last_reg;
   logic [RAM_DATA_WIDTH-1:0] fifo_data_reg [FIFO_DEPTH];
   logic                      fifo_last_reg [FIFO_DEPTH];
   logic [1:0]                wr_ptr_reg;
   logic [1:0]                rd_ptr_reg;
   logic [2:0]                count_reg;
   logic [2:0]                count_next;
   logic                      out_valid_reg;
   logic                      busy_reg;
   logic                      done_reg;

   logic pop;
   logic credit_ok;
   logic issue;
   logic issue_last;

   // A read in flight already owns a FIFO slot, so credits count it with occupancy.
   always_comb begin
      pop        = out_valid_reg & bus.out_ready;
      credit_ok  = (count_reg + 3'(pend_reg)) < 3'(FIFO_DEPTH);
      issue      = (state_reg == READ) && credit_ok;
      issue_last = issue && (rd_left_reg == (RAM_ADDR_WIDTH+1)'(1));
      count_next = count_reg + 3'(pend_reg) - 3'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         rd_left_reg   <= '0;
         pend_reg      <= 1'b0;
         pend_last_reg <= 1'b0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_reg[i] <= '0;
            fifo_last_reg[i] <= 1'b0;
         end
      end else begin
         done_reg      <= 1'b0;
         pend_reg      <= issue;
         pend_last_reg <= issue_last;
         count_reg     <= count_next;
         out_valid_reg <= (count_next != 3'd0);

         // BRAM data for the address issued on the previous edge is valid now.
         if (pend_reg) begin
            fifo_data_reg[wr_ptr_reg] <= bus.bram_data_out;
            fifo_last_reg[wr_ptr_reg] <= pend_last_reg;
            wr_ptr_reg                <= wr_ptr_reg + 2'd1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 2'd1;
         end

         case (state_reg)
            IDLE: begin
               if (bus.start && (bus.len != '0)) begin
                  addr_reg    <= bus.start_addr;
                  rd_left_reg <= bus.len;
                  busy_reg    <= 1'b1;
                  state_reg   <= READ;
               end
            end
            READ: begin
               if (issue) begin
                  addr_reg    <= addr_reg + RAM_ADDR_WIDTH'(1);
                  rd_left_reg <= rd_left_reg - (RAM_ADDR_WIDTH+1)'(1);
                  if (issue_last) begin
                     state_reg <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && fifo_last_reg[rd_ptr_reg]) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.bram_wr   = 1'b0;
   assign bus.bram_addr = addr_reg;
   assign bus.out_data  = fifo_data_reg[rd_ptr_reg];
   assign bus.out_valid = out_valid_reg;
   assign bus.out_last  = out_valid_reg & fifo_last_reg[rd_ptr_reg];
   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
endmodule

// File: tb/tb_bram_sp_reader.sv
// Self-checking bench for bram_sp_reader: table of bursts plus hand-written
// len=0 and mid-burst reset sequences, words checked against a scoreboard queue.
module tb_bram_sp_reader;
   localparam int DW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bram_sp_reader_if #(.DW(DW), .AW(AW)) bus ();

   bram_sp_reader #(.RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Synchronous single-port BRAM model, mem[i] = i + 0x10
   logic [DW-1:0] mem [16];
   logic [DW-1:0] bram_rdata;
   always @(posedge clk) bram_rdata <= mem[bus.bram_addr];
   assign bus.bram_data_out = bram_rdata;

   typedef struct {
      logic [AW-1:0] sa;
      logic [AW:0]   len;
      int            mode;      // 0: ready=1, 1: ready toggles, 2: ready=0 for 10 clks
      int            poke;      // cycle to pulse a stray start (0 = none)
      int            done_lat;  // expected cycles from start edge to done (0 = unchecked)
   } vec_t;

   vec_t vecs [7];

   int            n_vec = 0;
   int            n_err = 0;
   int            done_cnt = 0;
   logic [DW:0]   exp_q [$];
   logic [DW:0]   mon_exp;
   logic          stall_prev = 1'b0;
   logic [DW:0]   held;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Output monitor: scoreboard compare on transfer, stability while stalled
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_hold", 32'({bus.out_last, bus.out_data}), 32'(held));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 32'({bus.out_last, bus.out_data}), 32'h1ff);
            end else begin
               mon_exp = exp_q.pop_front();
               check("word", 32'({bus.out_last, bus.out_data}), 32'(mon_exp));
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held       = {bus.out_last, bus.out_data};
         if (bus.done) done_cnt++;
      end
   end

   // Called at #1 after an edge; start is sampled on the next edge.
   task automatic run_burst(input vec_t v);
      int            t;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bus.start      = 1'b1;
      bus.start_addr = v.sa;
      bus.len        = v.len;
      for (int i = 0; i < int'(v.len); i++) begin
         a = v.sa + AW'(i);
         d = 8'h10 + DW'(a);
         exp_q.push_back({(i == int'(v.len) - 1), d});
      end
      bus.out_ready = (v.mode != 2);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (t = 1; t <= 200; t++) begin
         @(posedge clk);
         #1;
         if (t == 1) begin
            check("busy_set", 32'(bus.busy), 32'd1);
            check("valid_early", 32'(bus.out_valid), 32'd0);
         end
         if (t == 2) begin
            check("first_valid", 32'(bus.out_valid), 32'd1);
            a = v.sa;
            d = 8'h10 + DW'(a);
            check("first_data", 32'(bus.out_data), 32'(d));
         end
         if (v.mode == 2 && t == 10) begin
            a = v.sa + AW'(4);
            check("stall_credit_addr", 32'(bus.bram_addr), 32'(a));
         end
         if (bus.done) break;
         bus.start = (t == v.poke);
         if (t == v.poke) begin
            bus.start_addr = 4'h9;
            bus.len        = 5'd2;
         end
         case (v.mode)
            1:       bus.out_ready = ~bus.out_ready;
            2:       bus.out_ready = (t >= 10);
            default: bus.out_ready = 1'b1;
         endcase
      end
      bus.start = 1'b0;
      if (v.done_lat > 0) check("done_latency", 32'(t), 32'(v.done_lat));
      else                check("done_seen", 32'(t <= 200), 32'd1);
      check("busy_clear", 32'(bus.busy), 32'd0);
      check("all_words_out", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] addr_before;
      vec_t          rv;

      for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
      vecs[0] = '{sa: 4'h2, len: 5'd4,  mode: 0, poke: 0, done_lat: 6};
      vecs[1] = '{sa: 4'hE, len: 5'd4,  mode: 0, poke: 0, done_lat: 6};
      vecs[2] = '{sa: 4'h0, len: 5'd16, mode: 1, poke: 0, done_lat: 0};
      vecs[3] = '{sa: 4'h0, len: 5'd8,  mode: 2, poke: 0, done_lat: 0};
      vecs[4] = '{sa: 4'h5, len: 5'd8,  mode: 0, poke: 3, done_lat: 10};
      vecs[5] = '{sa: 4'h7, len: 5'd16, mode: 0, poke: 0, done_lat: 18};
      vecs[6] = '{sa: 4'hF, len: 5'd1,  mode: 0, poke: 0, done_lat: 3};

      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.start_addr = '0;
      bus.len        = '0;
      bus.out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bram_addr", 32'(bus.bram_addr), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_last", 32'(bus.out_last), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("bram_wr", 32'(bus.bram_wr), 32'd0);
      rst = 1'b0;

      // Bursts run back to back: each start lands in the done cycle of the previous
      for (int i = 0; i < 7; i++) begin
         run_burst(vecs[i]);
      end

      // len=0 start is ignored
      addr_before    = bus.bram_addr;
      bus.start      = 1'b1;
      bus.start_addr = 4'h5;
      bus.len        = '0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("len0_busy", 32'(bus.busy), 32'd0);
      check("len0_addr", 32'(bus.bram_addr), 32'(addr_before));
      check("len0_valid", 32'(bus.out_valid), 32'd0);
      check("len0_no_done", 32'(done_cnt), 32'd7);

      // Reset after the 2nd word of a len=8 burst
      bus.out_ready  = 1'b1;
      bus.start      = 1'b1;
      bus.start_addr = 4'h0;
      bus.len        = 5'd8;
      for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 8'(i + 16)});
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("words_before_rst", 32'(exp_q.size()), 32'd6);
      rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_out_data", 32'(bus.out_data), 32'd0);
      check("arst_out_last", 32'(bus.out_last), 32'd0);
      check("arst_bram_addr", 32'(bus.bram_addr), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rv = '{sa: 4'h3, len: 5'd8, mode: 0, poke: 0, done_lat: 10};
      run_burst(rv);
      repeat (3) @(posedge clk);
      #1;
      check("done_pulse_count", 32'(done_cnt), 32'd8);
      check("bram_wr_end", 32'(bus.bram_wr), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
